// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM state encoding and the
// default values of the scanner parameters.
package keypad_pkg;

   localparam int ROWS_DEF            = 4;
   localparam int COLS_DEF            = 4;
   localparam int SCAN_CYCLES_DEF     = 4;
   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int FIFO_DEPTH_DEF      = 4;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      RELEASE  = 2'd2
   } scan_state_t;

endpackage

// File: rtl/key_fifo.sv
// Key-code buffer: small synchronous FIFO with valid/ready pop.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   push         write push_data this cycle (ignored when full without a pop)
//   push_data    code to store
//   ready        consumer takes the head this cycle (pops when valid)
//   valid        FIFO not empty
//   head         oldest entry, 0 while empty
//   full         all DEPTH entries occupied
module key_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] head,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             pop;
   logic             wr_en;

   // Extra pointer bit distinguishes full from empty when the indices meet.
   assign valid = (wr_ptr != rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = valid & ready;
   // A full buffer still accepts when the head leaves in the same cycle.
   assign wr_en = push & (~full | pop);
   assign head  = valid ? mem[rd_ptr[AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one row at a time, qualifies a single key
// press with debounce, waits for a debounced release, and queues the key
// codes (row*COLS + col) in a small FIFO.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   col_i         raw column sense (asynchronous, active-high)
//   row_drv_o     one-hot row drive
//   key_valid_o   a key code is available
//   key_code_o    oldest queued key code
//   key_ready_i   consumer takes key_code_o this cycle
//   overflow_o    sticky: a qualified key was dropped on a full FIFO
//   clr_ovf_i     clears overflow_o
//
// state    | meaning
// SCAN     | cycle through rows, sample columns at the end of each slot
// DEBOUNCE | row held, single-key candidate must stay stable
// RELEASE  | row held, waiting for a stable all-released column pattern
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter  int ROWS            = ROWS_DEF,
   parameter  int COLS            = COLS_DEF,
   parameter  int SCAN_CYCLES     = SCAN_CYCLES_DEF,
   parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter  int FIFO_DEPTH      = FIFO_DEPTH_DEF,
   localparam int CW              = $clog2(ROWS*COLS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [COLS-1:0] col_i,
   output logic [ROWS-1:0] row_drv_o,
   output logic            key_valid_o,
   output logic [CW-1:0]   key_code_o,
   input  logic            key_ready_i,
   output logic            overflow_o,
   input  logic            clr_ovf_i
);

   localparam int RW  = $clog2(ROWS);
   localparam int SW  = $clog2(SCAN_CYCLES);
   localparam int DW  = $clog2(DEBOUNCE_CYCLES);
   localparam int CIW = $clog2(COLS);

   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

   scan_state_t     state, state_nxt;
   logic [RW-1:0]   row_idx, row_nxt, row_inc;
   logic [SW-1:0]   slot_cnt, slot_nxt;
   logic [DW-1:0]   deb_cnt, deb_nxt;
   logic [COLS-1:0] cand_col, cand_nxt;
   logic [COLS-1:0] col_s1, col_s2;
   logic [CIW-1:0]  col_idx;
   logic [CW-1:0]   push_code;
   logic            push;
   logic            pop;
   logic            full;
   logic            drop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_s1 <= '0;
         col_s2 <= '0;
      end else begin
         col_s1 <= col_i;
         col_s2 <= col_s1;
      end
   end

   assign row_drv_o = ROWS'(1) << row_idx;
   assign row_inc   = (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;

   always_comb begin
      col_idx = '0;
      for (int c = 0; c < COLS; c++) begin
         if (cand_col[c]) col_idx = CIW'(c);
      end
   end

   assign push_code = CW'(row_idx) * CW'(COLS) + CW'(col_idx);

   always_comb begin
      state_nxt = state;
      row_nxt   = row_idx;
      slot_nxt  = slot_cnt;
      deb_nxt   = deb_cnt;
      cand_nxt  = cand_col;
      push      = 1'b0;
      case (state)
         SCAN: begin
            // Only the last cycle of a slot is sampled, so the synchroniser
            // has flushed the previous row's columns by then.
            if (slot_cnt == SLOT_LAST) begin
               slot_nxt = '0;
               if ($countones(col_s2) == 1) begin
                  cand_nxt  = col_s2;
                  deb_nxt   = '0;
                  state_nxt = DEBOUNCE;
               end else begin
                  row_nxt = row_inc;
               end
            end else begin
               slot_nxt = slot_cnt + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (col_s2 == cand_col) begin
               if (deb_cnt == DEB_LAST) begin
                  push      = 1'b1;
                  deb_nxt   = '0;
                  state_nxt = RELEASE;
               end else begin
                  deb_nxt = deb_cnt + 1'b1;
               end
            end else begin
               deb_nxt   = '0;
               row_nxt   = row_inc;
               state_nxt = SCAN;
            end
         end
         RELEASE: begin
            if (col_s2 == '0) begin
               if (deb_cnt == DEB_LAST) begin
                  deb_nxt   = '0;
                  row_nxt   = row_inc;
                  state_nxt = SCAN;
               end else begin
                  deb_nxt = deb_cnt + 1'b1;
               end
            end else begin
               deb_nxt = '0;
            end
         end
         default: begin
            state_nxt = SCAN;
            row_nxt   = '0;
            slot_nxt  = '0;
            deb_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= SCAN;
         row_idx  <= '0;
         slot_cnt <= '0;
         deb_cnt  <= '0;
         cand_col <= '0;
      end else begin
         state    <= state_nxt;
         row_idx  <= row_nxt;
         slot_cnt <= slot_nxt;
         deb_cnt  <= deb_nxt;
         cand_col <= cand_nxt;
      end
   end

   key_fifo #(
      .WIDTH (CW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_code),
      .ready     (key_ready_i),
      .valid     (key_valid_o),
      .head      (key_code_o),
      .full      (full)
   );

   assign pop  = key_valid_o & key_ready_i;
   assign drop = push & full & ~pop;

   // A drop in the same cycle as a clear request keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           overflow_o <= 1'b0;
      else if (drop)      overflow_o <= 1'b1;
      else if (clr_ovf_i) overflow_o <= 1'b0;
   end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

   localparam int ROWS            = 4;
   localparam int COLS            = 4;
   localparam int SCAN_CYCLES     = 4;
   localparam int DEBOUNCE_CYCLES = 8;
   localparam int FIFO_DEPTH      = 4;
   localparam int CW              = 4;
   localparam int HOLD            = 60;
   localparam int QUIET           = 40;

   logic            clk;
   logic            rst;
   logic [COLS-1:0] col_i;
   logic [ROWS-1:0] row_drv_o;
   logic            key_valid_o;
   logic [CW-1:0]   key_code_o;
   logic            key_ready_i;
   logic            overflow_o;
   logic            clr_ovf_i;

   // Physical keypad: pressed switches connect a driven row to its columns.
   logic [ROWS*COLS-1:0] key_mat;
   logic                 ovr_en;
   logic [COLS-1:0]      ovr_val;
   logic [COLS-1:0]      kp_cols;

   int n_checks;
   int n_fail;
   int got[$];
   int exp_q[$];

   keypad_scanner #(
      .ROWS            (ROWS),
      .COLS            (COLS),
      .SCAN_CYCLES     (SCAN_CYCLES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .FIFO_DEPTH      (FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .col_i       (col_i),
      .row_drv_o   (row_drv_o),
      .key_valid_o (key_valid_o),
      .key_code_o  (key_code_o),
      .key_ready_i (key_ready_i),
      .overflow_o  (overflow_o),
      .clr_ovf_i   (clr_ovf_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      kp_cols = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (row_drv_o[r] && key_mat[r*COLS+c]) kp_cols[c] = 1'b1;
   end

   assign col_i = ovr_en ? ovr_val : kp_cols;

   // Called at a falling edge; records what the next rising edge pops.
   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         if (key_valid_o && key_ready_i) got.push_back(int'(key_code_o));
         @(negedge clk);
      end
   endtask

   task automatic wait_row(input logic [ROWS-1:0] pat, input bit want_eq, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if ((row_drv_o == pat) == want_eq) begin
            ok = 1'b1;
            break;
         end
         run_cycles(1);
      end
   endtask

   task automatic press_release(input int code, input int hold, input int quiet);
      key_mat[code] = 1'b1;
      run_cycles(hold);
      key_mat = '0;
      run_cycles(quiet);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (row_drv_o !== 4'b0001) begin
         n_fail++; $display("FAIL reset_row: got %b expected 0001", row_drv_o);
      end
      n_checks++;
      if (key_valid_o !== 1'b0 || key_code_o !== 4'd0 || overflow_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b code=%0d ovf=%b expected 0/0/0",
                  key_valid_o, key_code_o, overflow_o);
      end
   endtask

   task automatic test_idle_scan();
      logic [ROWS-1:0] exp_row;
      rst = 1'b1;
      for (int i = 0; i < 5 * SCAN_CYCLES; i++) begin
         exp_row = ROWS'(1) << ((i / SCAN_CYCLES) % ROWS);
         n_checks++;
         if (row_drv_o !== exp_row || key_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_scan[%0d]: got row=%b valid=%b expected row=%b valid=0",
                     i, row_drv_o, key_valid_o, exp_row);
         end
         run_cycles(1);
      end
   endtask

   task automatic test_single_press();
      key_ready_i = 1'b1;
      got.delete();
      key_mat[1*COLS+2] = 1'b1;
      run_cycles(HOLD);
      n_checks++;
      if (got.size() != 1 || got[0] != 6) begin
         n_fail++;
         $display("FAIL single_press: got %0d codes first=%0d expected 1 code 6",
                  got.size(), (got.size() > 0) ? got[0] : -1);
      end
      key_mat = '0;
      run_cycles(QUIET);
      n_checks++;
      if (got.size() != 1) begin
         n_fail++; $display("FAIL single_no_repeat: got %0d codes expected 1", got.size());
      end
   endtask

   task automatic test_random_presses();
      int code;
      key_ready_i = 1'b1;
      got.delete();
      exp_q.delete();
      for (int k = 0; k < 8; k++) begin
         code = int'($urandom_range(0, ROWS*COLS-1));
         exp_q.push_back(code);
         press_release(code, HOLD, QUIET);
      end
      n_checks++;
      if (got.size() != exp_q.size()) begin
         n_fail++; $display("FAIL random_count: got %0d expected %0d", got.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            n_checks++;
            if (got[i] != exp_q[i]) begin
               n_fail++; $display("FAIL random_code[%0d]: got %0d expected %0d", i, got[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_glitch();
      bit ok;
      key_ready_i = 1'b1;
      got.delete();
      wait_row(4'b0100, 1'b0, ok);
      wait_row(4'b0100, 1'b1, ok);
      n_checks++;
      if (!ok) begin
         n_fail++; $display("FAIL glitch_wait_row2: got row=%b expected 0100", row_drv_o);
      end
      ovr_en  = 1'b1;
      ovr_val = 4'b0001;
      run_cycles(3);
      ovr_val = 4'b0000;
      wait_row(4'b0100, 1'b0, ok);
      n_checks++;
      if (!ok || row_drv_o !== 4'b1000) begin
         n_fail++; $display("FAIL glitch_next_row: got row=%b expected 1000", row_drv_o);
      end
      run_cycles(HOLD);
      ovr_en = 1'b0;
      n_checks++;
      if (got.size() != 0) begin
         n_fail++; $display("FAIL glitch_no_code: got %0d codes expected 0", got.size());
      end
   endtask

   task automatic test_ghost();
      int r, c0, c1;
      key_ready_i = 1'b1;
      got.delete();
      key_mat[0*COLS+1] = 1'b1;
      key_mat[0*COLS+2] = 1'b1;
      run_cycles(HOLD + 20);
      key_mat = '0;
      run_cycles(QUIET);
      for (int k = 0; k < 3; k++) begin
         r  = int'($urandom_range(0, ROWS-1));
         c0 = int'($urandom_range(0, COLS-1));
         c1 = (c0 + 1 + int'($urandom_range(0, COLS-2))) % COLS;
         key_mat[r*COLS+c0] = 1'b1;
         key_mat[r*COLS+c1] = 1'b1;
         run_cycles(HOLD + 20);
         key_mat = '0;
         run_cycles(QUIET);
      end
      n_checks++;
      if (got.size() != 0) begin
         n_fail++; $display("FAIL ghost_no_code: got %0d codes expected 0", got.size());
      end
   endtask

   task automatic test_overflow();
      int codes[5] = '{0, 5, 10, 15, 3};
      key_ready_i = 1'b0;
      got.delete();
      for (int k = 0; k < 5; k++) begin
         press_release(codes[k], HOLD, QUIET);
         if (k == 3) begin
            n_checks++;
            if (overflow_o !== 1'b0 || key_valid_o !== 1'b1 || key_code_o !== 4'd0) begin
               n_fail++;
               $display("FAIL ovf_full_no_drop: got ovf=%b valid=%b head=%0d expected 0/1/0",
                        overflow_o, key_valid_o, key_code_o);
            end
         end
      end
      n_checks++;
      if (overflow_o !== 1'b1) begin
         n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow_o);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (key_code_o !== 4'd0 || key_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL ovf_head_stable: got code=%0d valid=%b expected 0/1", key_code_o, key_valid_o);
         end
         run_cycles(1);
      end
      key_ready_i = 1'b1;
      run_cycles(8);
      key_ready_i = 1'b0;
      n_checks++;
      if (got.size() != 4) begin
         n_fail++; $display("FAIL ovf_pop_count: got %0d expected 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got[i] != codes[i]) begin
               n_fail++; $display("FAIL ovf_pop[%0d]: got %0d expected %0d", i, got[i], codes[i]);
            end
         end
      end
      n_checks++;
      if (overflow_o !== 1'b1 || key_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL ovf_sticky: got ovf=%b valid=%b expected 1/0", overflow_o, key_valid_o);
      end
      clr_ovf_i = 1'b1;
      run_cycles(1);
      clr_ovf_i = 1'b0;
      n_checks++;
      if (overflow_o !== 1'b0) begin
         n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow_o);
      end
   endtask

   task automatic test_back_to_back();
      key_ready_i = 1'b0;
      got.delete();
      exp_q.delete();
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(int'($urandom_range(0, ROWS*COLS-1)));
         press_release(exp_q[k], HOLD, QUIET);
         n_checks++;
         if (key_valid_o !== 1'b1 || int'(key_code_o) != exp_q[0]) begin
            n_fail++;
            $display("FAIL b2b_head[%0d]: got valid=%b code=%0d expected 1/%0d",
                     k, key_valid_o, key_code_o, exp_q[0]);
         end
      end
      key_ready_i = 1'b1;
      run_cycles(3);
      n_checks++;
      if (got.size() != 3 || key_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL b2b_count: got %0d valid=%b expected 3/0", got.size(), key_valid_o);
      end else begin
         foreach (exp_q[i]) begin
            n_checks++;
            if (got[i] != exp_q[i]) begin
               n_fail++; $display("FAIL b2b_pop[%0d]: got %0d expected %0d", i, got[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_debounce();
      int cnt;
      bit hit;
      key_ready_i = 1'b1;
      got.delete();
      key_mat[2*COLS+1] = 1'b1;
      cnt = 0;
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         run_cycles(1);
         if (row_drv_o == 4'b0100) cnt++;
         else cnt = 0;
         if (cnt == SCAN_CYCLES + 2) begin
            hit = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!hit) begin
         n_fail++; $display("FAIL rstdeb_reach: got no held row 2 expected row 0100 held");
      end
      n_checks++;
      if (got.size() != 0) begin
         n_fail++; $display("FAIL rstdeb_early_push: got %0d codes expected 0", got.size());
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (row_drv_o !== 4'b0001 || key_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL rstdeb_async: got row=%b valid=%b expected 0001/0", row_drv_o, key_valid_o);
      end
      key_mat = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_cycles(HOLD);
      n_checks++;
      if (got.size() != 0) begin
         n_fail++; $display("FAIL rstdeb_no_code: got %0d codes expected 0", got.size());
      end
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b0;
      key_mat     = '0;
      ovr_en      = 1'b0;
      ovr_val     = '0;
      key_ready_i = 1'b0;
      clr_ovf_i   = 1'b0;
      test_reset();
      test_idle_scan();
      test_single_press();
      test_random_presses();
      test_glitch();
      test_ghost();
      test_overflow();
      test_back_to_back();
      test_reset_mid_debounce();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test expected finish before time limit");
      $fatal(1);
   end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of keypad rows driven (2..8).
REQ-002 Parameter COLS, default 4, number of keypad columns sensed (2..8).
REQ-003 Parameter SCAN_CYCLES, default 4, clock cycles each row is driven per scan slot (>=3).
REQ-004 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles for press and release qualification (>=2).
REQ-005 Parameter FIFO_DEPTH, default 4, key-code buffer entries (power of two, >=2).
REQ-006 Local CW = clog2(ROWS*COLS), the key code width.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 col_i  input  COLS  raw column sense, asynchronous, active-high.
REQ-010 row_drv_o  output  ROWS  one-hot row drive, active-high.
REQ-011 key_valid_o  output  1  FIFO non-empty.
REQ-012 key_code_o  output  CW  FIFO head; code = row*COLS + col.
REQ-013 key_ready_i  input  1  consumer accepts the head this cycle.
REQ-014 overflow_o  output  1  sticky; a qualified key was dropped.
REQ-015 clr_ovf_i  input  1  clears overflow_o.

Function
REQ-016 col_i SHALL pass through a 2-flop synchroniser; all decisions use the synchronised value (colS).
REQ-017 FSM states SHALL be SCAN, DEBOUNCE, RELEASE.
REQ-018 SCAN: drive the current row for SCAN_CYCLES cycles; sample colS only in the last cycle of the slot; then advance to the next row, wrapping ROWS-1 -> 0.
REQ-019 SCAN sample with exactly one colS bit set SHALL latch the candidate (row, col), hold the row, and go to DEBOUNCE with counter 0.
REQ-020 SCAN sample with zero or more than one bit set SHALL be ignored; ghost/multi-key never produces a code.
REQ-021 DEBOUNCE: each cycle colS equals the candidate one-hot pattern, increment the counter; any mismatch returns to SCAN at the next row with no push.
REQ-022 On the DEBOUNCE_CYCLES-th consecutive match, push the code in that cycle and go to RELEASE.
REQ-023 RELEASE: hold the row; require DEBOUNCE_CYCLES consecutive cycles of colS == 0; any nonzero restarts the count; then go to SCAN at the next row.
REQ-024 FIFO: key_valid_o = not empty; key_code_o = head; pop when key_valid_o && key_ready_i.
REQ-025 A push into an empty FIFO SHALL assert key_valid_o on the following cycle.
REQ-026 Push when full without a same-cycle pop SHALL drop the code, keep contents, and set overflow_o.
REQ-027 Push when full with a same-cycle pop SHALL be accepted; no overflow.
REQ-028 Codes SHALL leave in press order; key_code_o SHALL stay stable while key_valid_o && !key_ready_i.
REQ-029 clr_ovf_i clears overflow_o next cycle; a simultaneous overflow event wins (overflow_o stays 1).

Reset
REQ-030 While rst is low: row_drv_o = 1 (row 0), state SCAN, all counters 0, FIFO empty, key_valid_o = 0, key_code_o = 0, overflow_o = 0, synchroniser flops 0.
REQ-031 Reset asserted mid-DEBOUNCE or mid-RELEASE SHALL discard the candidate with no push.

Structure
REQ-032 Package keypad_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-033 The FIFO SHALL be a sub-module key_fifo (parametrised width/depth, valid/ready pop, full flag).

Verification (ROWS=4, COLS=4, SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, FIFO_DEPTH=4)
REQ-034 Idle after reset release -> row_drv_o 0001, 0010, 0100, 1000, 0001, 4 cycles each; key_valid_o = 0.
REQ-035 col_i = 0100 while row 1 driven, held 60 cycles, key_ready_i = 1 -> exactly one pop of code 6; no repeat until release plus 8 quiet cycles.
REQ-036 col_i = 0001 on row 2 for 3 cycles, then 0 -> no code; scan resumes at row 3.
REQ-037 col_i = 0110 on row 0 -> no code ever.
REQ-038 Five distinct presses (codes 0, 5, 10, 15, 3) with key_ready_i = 0 -> overflow_o = 1; pops yield 0, 5, 10, 15; clr_ovf_i pulse -> overflow_o = 0.
REQ-039 rst low during DEBOUNCE of code 9 -> immediately row_drv_o = 0001, key_valid_o = 0; code 9 never appears.
